binary_down_counter: RTL and testbench
======================================

Name: binary_down_counter

Overview:
Loadable down-counter and terminal-count timer; the counting-down counterpart to the team's free-running binary up-counter.
- Accepts a start value over a valid/ready load handshake.
- Decrements to zero under a count enable, then reports expiry with a one-cycle done pulse.
- Used wherever a block must wait a programmed number of enabled cycles: timeouts, inter-frame gaps, retry back-off.

Parameters:
WIDTH, 4, bit width of count, load_value and the internal reload register

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
load_valid  input  1  start value offered
load_ready  output  1  block can accept a start value
load_value  input  WIDTH  start value, sampled on handshake
enable  input  1  decrement qualifier while running
abort  input  1  synchronous cancel of a running count
count  output  WIDTH  current remaining count (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle expiry pulse (registered)
reload_en  input  1  present only with AUTO_RELOAD_EN

Behaviour:
- Interface: one clock (clk); reset (reset_n) is asynchronous and active-low.
- Reset (reset_n low, asynchronous, any state):
  - state=IDLE, count=0, reload register=0
  - busy=0, done=0, load_ready=1
- Reset deassertion is synchronous to clk; first active edge follows reset_n high.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from the registered state; no combinational input-to-output path.
- load_ready=1 only in IDLE. busy=1 only in RUN.
- IDLE:
  - Handshake = load_valid && load_ready at a rising edge.
  - On handshake: count<=load_value, reload register<=load_value.
  - load_value!=0 -> RUN. load_value==0 -> DONE directly.
  - abort and enable are ignored in IDLE.
- RUN, priority abort > enable:
  - abort=1 -> IDLE, count<=0, no done pulse.
  - enable=1, count>1 -> count<=count-1, stay RUN.
  - enable=1, count==1 -> count<=0, go DONE.
  - enable=0 -> hold count and state.
- DONE: done=1 for exactly one cycle, count=0, busy=0; unconditional transition to IDLE on next edge.
- Latency: load N>=1 with enable held high -> N decrement edges after the acceptance edge, then done high for one cycle; load_ready returns high the cycle after done.
- Underflow: count never goes below 0 and never wraps from 0 to all-ones.
- load_value all-ones (2^WIDTH-1) counts fully; no overflow is possible.
- Back-to-back operation: the earliest next load handshake is the first IDLE cycle after DONE; there is one dead cycle (DONE) between runs.
- Reset mid-RUN: count forced to 0 immediately; no done pulse is generated.

Optional Feature:
Macro: BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
- Defined:
  - Input port reload_en exists.
  - In RUN with enable=1, count==1 and reload_en=1: count<=reload register, stay RUN, done pulses high for the following cycle.
  - Period is N enabled cycles; count shows N..1 repeatedly, never 0.
  - reload_en=0 at the terminal decrement gives base behaviour.
  - abort still returns to IDLE with no pulse.
  - load_value==0 always takes the base DONE path, once.
- Undefined: no reload_en port, no reload path; the reload register may be optimised out. Behaviour is identical to the base description.

Test Plan:
- Reset/idle: reset_n low mid-RUN with count=5 -> same-cycle count=0, busy=0, done=0, load_ready=1; no done pulse afterwards.
- Basic countdown: load 3, enable held high -> count 3,2,1,0 on successive edges; done high for exactly 1 cycle; load_ready high the next cycle.
- Enable gaps: load 4, enable pattern 1,0,0,1,1,0,1 -> count 3,3,3,2,1,1,0; done follows the final decrement only.
- Zero and maximum: load 0 -> DONE next cycle, done pulse, no RUN cycle. Load 15 (WIDTH=4) -> 15 enabled edges to 0, no wrap to 15.
- Abort versus enable: load 6, after 2 decrements assert abort and enable together -> IDLE, count=0, no done; an immediate new load of 2 is accepted.
- Auto-reload (macro defined): load 3, reload_en=1, enable high for 10 cycles -> count 3,2,1,3,2,1,3,2,1,3; done pulses every 3rd cycle. Drop reload_en before the next terminal edge -> final count 0, DONE, single done pulse.

Source files
------------

// File: rtl/binary_down_counter.sv
// Loadable down-counter / terminal-count timer.
// A start value is accepted over a valid/ready handshake while idle. The counter then
// decrements on each enabled cycle until it reaches zero, and expiry is flagged by a
// one-cycle done pulse.
// Optional build macro BINARY_DOWN_COUNTER_AUTO_RELOAD_EN adds the reload_en input.
// When reload_en is high at the terminal decrement, the counter reloads the last start
// value and keeps running instead of stopping.
module binary_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
  input  logic             reload_en,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state, next-count and done-pulse decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          count_d = load_value;
`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
          // A zero start value expires immediately without a RUN cycle
          if (load_value == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          count_d = '0;
        end else if (enable) begin
          if (count_q == CountOne) begin
`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
            if (reload_en) begin
              // Terminal edge with reload: restart the period, pulse done, stay running
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              state_d = StDone;
              done_d  = 1'b1;
            end
`else
            count_d = '0;
            state_d = StDone;
            done_d  = 1'b1;
`endif
          end else begin
            // count_q is always >= 1 in RUN, so this never wraps
            count_d = count_q - CountOne;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        count_d = '0;
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // State, count and done registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
  // Holds the last accepted start value for auto-reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // Outputs come straight from registers or the registered state
  always_comb begin
    load_ready = (state_q == StIdle);
    busy       = (state_q == StRun);
    count      = count_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_binary_down_counter.sv
// Self-checking bench for binary_down_counter (WIDTH=4).
// The bench combines a vector table, hand-written corner-case sequences and random
// stimulus. Results are checked against a behavioural model of the remaining count and
// the run/expiry phases.
module tb_binary_down_counter;

  localparam int unsigned Width = 4;
`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             load_valid;
  logic             load_ready;
  logic [Width-1:0] load_value;
  logic             enable;
  logic             abort;
  logic             reload_en;
  logic [Width-1:0] count;
  logic             busy;
  logic             done;

  int n_checks;
  int n_errors;

  // Behavioural model state
  int m_cnt;
  int m_rel;
  bit m_run;
  bit m_in_done;
  bit m_done;

  binary_down_counter #(.WIDTH(Width)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .enable     (enable),
    .abort      (abort),
`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
    .reload_en  (reload_en),
`endif
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [3:0] val;
    logic       en;
    logic       ab;
    logic [3:0] ec;
    logic       eb;
    logic       ed;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_rel     = 0;
    m_run     = 1'b0;
    m_in_done = 1'b0;
    m_done    = 1'b0;
  endtask

  // One rising edge of the specified behaviour
  task automatic model_step(input bit lv, input int val, input bit en, input bit ab,
                            input bit rl);
    if (m_in_done) begin
      m_in_done = 1'b0;
      m_done    = 1'b0;
      m_cnt     = 0;
    end else if (!m_run) begin
      m_done = 1'b0;
      if (lv) begin
        m_cnt = val;
        m_rel = val;
        if (val == 0) begin
          m_in_done = 1'b1;
          m_done    = 1'b1;
        end else begin
          m_run = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (ab) begin
        m_run = 1'b0;
        m_cnt = 0;
      end else if (en) begin
        if (m_cnt > 1) begin
          m_cnt = m_cnt - 1;
        end else if (Auto && rl) begin
          m_cnt  = m_rel;
          m_done = 1'b1;
        end else begin
          m_cnt     = 0;
          m_run     = 1'b0;
          m_in_done = 1'b1;
          m_done    = 1'b1;
        end
      end
    end
  endtask

  // Entered at a negedge: apply inputs, clock once, compare against the model at negedge
  task automatic drive(input bit lv, input int val, input bit en, input bit ab, input bit rl);
    load_valid = lv;
    load_value = val[Width-1:0];
    enable     = en;
    abort      = ab;
    reload_en  = rl;
    @(posedge clk);
    model_step(lv, val, en, ab, rl);
    @(negedge clk);
    chk("mdl_count", int'(count), m_cnt);
    chk("mdl_busy", int'(busy), int'(m_run));
    chk("mdl_done", int'(done), int'(m_done));
    chk("mdl_ready", int'(load_ready), int'(!(m_run || m_in_done)));
  endtask

  task automatic add(input bit lv, input int val, input bit en, input bit ab,
                     input int ec, input bit eb, input bit ed, input bit er);
    vec_t v;
    v.lv  = lv;
    v.val = val[3:0];
    v.en  = en;
    v.ab  = ab;
    v.ec  = ec[3:0];
    v.eb  = eb;
    v.ed  = ed;
    v.er  = er;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    enable     = 1'b0;
    abort      = 1'b0;
    reload_en  = 1'b0;
    model_reset();
    do_reset();

    // Reset state
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(load_ready), 1);

    // Basic countdown of 3
    add(1, 3, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Enable gaps on a load of 4; a load offered mid-run is ignored
    add(1, 4, 0, 0, 4, 1, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0, 0);
    add(1, 9, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Zero load goes straight to the expiry cycle
    add(1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Abort beats enable, then an immediate reload of 2
    add(1, 6, 0, 0, 6, 1, 0, 0);
    add(0, 0, 1, 0, 5, 1, 0, 0);
    add(0, 0, 1, 0, 4, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(1, 2, 0, 0, 2, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Enable and abort are ignored while idle
    add(0, 0, 1, 1, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].lv, int'(tbl[i].val), tbl[i].en, tbl[i].ab, 1'b0);
      chk($sformatf("vec%0d_count", i), int'(count), int'(tbl[i].ec));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].ed));
      chk($sformatf("vec%0d_ready", i), int'(load_ready), int'(tbl[i].er));
    end

    // Full-scale load counts all the way down without wrapping
    drive(1, 15, 0, 0, 0);
    chk("max_load", int'(count), 15);
    for (int i = 14; i >= 0; i--) begin
      drive(0, 0, 1, 0, 0);
      chk("max_count", int'(count), i);
      chk("max_done", int'(done), int'(i == 0));
    end
    drive(0, 0, 1, 0, 0);
    chk("max_after", int'(count), 0);
    chk("max_ready", int'(load_ready), 1);

    // Asynchronous reset in the middle of a run
    drive(1, 5, 0, 0, 0);
    chk("mid_load", int'(count), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_ready", int'(load_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0);
      chk("arst_nodone", int'(done), 0);
    end

`ifdef BINARY_DOWN_COUNTER_AUTO_RELOAD_EN
    // Auto-reload: period 3, then drop reload_en for a final expiry
    drive(1, 3, 0, 0, 1);
    chk("ar_load", int'(count), 3);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 0, 1);
      chk("ar_count", int'(count), 2 - (i % 3) + ((i % 3) == 2 ? 3 : 0));
      chk("ar_done", int'(done), int'((i % 3) == 2));
      chk("ar_busy", int'(busy), 1);
    end
    drive(0, 0, 1, 0, 0);
    chk("ar_stop2", int'(count), 2);
    drive(0, 0, 1, 0, 0);
    chk("ar_stop1", int'(count), 1);
    drive(0, 0, 1, 0, 0);
    chk("ar_stop0", int'(count), 0);
    chk("ar_stopdone", int'(done), 1);
    drive(0, 0, 0, 0, 0);
    chk("ar_idle_done", int'(done), 0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 3) == 0, int'($urandom % 16), ($urandom % 4) != 0,
            ($urandom % 12) == 0, ($urandom % 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
